// File: rtl/slot_reel_ctrl_pkg.sv
// Shared types for the slot reel controller: FSM states, result codes, symbol width,
// and the outcome classifier used by the evaluator.
package slot_pkg;

    localparam int unsigned SYM_W = 4;

    typedef enum logic [1:0] {IDLE, SPIN, EVAL} state_e;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PAIR    = 2'd1,
        RES_TRIPLE  = 2'd2,
        RES_JACKPOT = 2'd3
    } result_e;

    function automatic result_e classify(input logic [SYM_W-1:0] a,
                                         input logic [SYM_W-1:0] b,
                                         input logic [SYM_W-1:0] c,
                                         input logic [SYM_W-1:0] jack);
        if (a == b && b == c) begin
            return (a == jack) ? RES_JACKPOT : RES_TRIPLE;
        end
        if (a == b || b == c || a == c) begin
            return RES_PAIR;
        end
        return RES_NONE;
    endfunction

endpackage

// File: rtl/slot_reel_ctrl_if.sv
// Player/generator/display bundle for the slot reel controller.
interface slot_reel_ctrl_if #(
    parameter int unsigned CREDIT_W = 8
);
    logic                       start;
    logic                       step_tick;
    logic [slot_pkg::SYM_W-1:0] rand_num;
    logic                       rand_en;
    logic [slot_pkg::SYM_W-1:0] reel0;
    logic [slot_pkg::SYM_W-1:0] reel1;
    logic [slot_pkg::SYM_W-1:0] reel2;
    logic [2:0]                 reel_stopped;
    logic                       busy;
    logic [1:0]                 result;
    logic                       result_valid;
    logic [CREDIT_W-1:0]        credits;
    logic                       no_credit;

    // Driver side: player buttons, tick strobe and generator.
    modport master (
        output start, step_tick, rand_num,
        input  rand_en, reel0, reel1, reel2, reel_stopped, busy,
        input  result, result_valid, credits, no_credit
    );

    // Controller side.
    modport slave (
        input  start, step_tick, rand_num,
        output rand_en, reel0, reel1, reel2, reel_stopped, busy,
        output result, result_valid, credits, no_credit
    );
endinterface

// File: rtl/slot_reel_ctrl_reel_unit.sv
// One reel: spins (+1 mod 16) while not stopped, latches a generator value on load.
module reel_unit
    import slot_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             adv,
    input  logic             load,
    input  logic [SYM_W-1:0] din,
    output logic [SYM_W-1:0] sym,
    output logic             stopped
);

    // Reel symbol and stopped flag; load wins over advance, stopped reels hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym     <= '0;
            stopped <= 1'b1;
        end else if (clear) begin
            stopped <= 1'b0;
        end else if (load) begin
            sym     <= din;
            stopped <= 1'b1;
        end else if (adv && !stopped) begin
            sym <= sym + 1'b1;
        end
    end

endmodule

// File: rtl/slot_reel_ctrl.sv
// Slot reel controller: takes a bet on start, spins three reels on the step tick,
// stops them in turn on generator values, then classifies and pays out.
module slot_reel_ctrl
    import slot_pkg::*;
#(
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned INIT_CREDITS = 10,
    parameter int unsigned BET          = 1,
    parameter int unsigned SPIN_TICKS   = 8,
    parameter int unsigned STOP_GAP     = 4,
    parameter int unsigned PAY_PAIR     = 2,
    parameter int unsigned PAY_TRIPLE   = 10,
    parameter int unsigned PAY_JACKPOT  = 50,
    parameter int unsigned JACKPOT_SYM  = 7
) (
    input logic       clk,
    input logic       rst,
    slot_reel_ctrl_if.slave bus
);

    localparam int unsigned STOP0 = SPIN_TICKS;
    localparam int unsigned STOP1 = SPIN_TICKS + STOP_GAP;
    localparam int unsigned STOP2 = SPIN_TICKS + 2 * STOP_GAP;
    localparam int unsigned CNT_W = $clog2(STOP2 + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, tick_n;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    result_e             result_q, result_d, res_w;
    logic                result_valid_q, result_valid_d;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W:0]   payout;
    logic                clear, adv, load0, load1, load2;
    logic [SYM_W-1:0]    sym0, sym1, sym2;
    logic                stop0, stop1, stop2;

    reel_unit u_reel0 (.clk(clk), .rst(rst), .clear(clear), .adv(adv), .load(load0),
                       .din(bus.rand_num), .sym(sym0), .stopped(stop0));
    reel_unit u_reel1 (.clk(clk), .rst(rst), .clear(clear), .adv(adv), .load(load1),
                       .din(bus.rand_num), .sym(sym1), .stopped(stop1));
    reel_unit u_reel2 (.clk(clk), .rst(rst), .clear(clear), .adv(adv), .load(load2),
                       .din(bus.rand_num), .sym(sym2), .stopped(stop2));

    // Outcome and saturating credit sum, evaluated at CREDIT_W+1 bits.
    always_comb begin
        res_w = classify(sym0, sym1, sym2, SYM_W'(JACKPOT_SYM));
        case (res_w)
            RES_PAIR:    payout = (CREDIT_W + 1)'(PAY_PAIR);
            RES_TRIPLE:  payout = (CREDIT_W + 1)'(PAY_TRIPLE);
            RES_JACKPOT: payout = (CREDIT_W + 1)'(PAY_JACKPOT);
            default:     payout = '0;
        endcase
        sum = {1'b0, credits_q} + payout;
    end

    // FSM next state, tick counting, reel control and credit updates.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        credits_d      = credits_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        clear          = 1'b0;
        adv            = 1'b0;
        load0          = 1'b0;
        load1          = 1'b0;
        load2          = 1'b0;
        tick_n         = cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.no_credit) begin
                    credits_d = credits_q - CREDIT_W'(BET);
                    result_d  = RES_NONE;
                    cnt_d     = '0;
                    clear     = 1'b1;
                    state_d   = SPIN;
                end
            end
            SPIN: begin
                if (bus.step_tick) begin
                    cnt_d = tick_n;
                    adv   = 1'b1;
                    load0 = (tick_n == CNT_W'(STOP0));
                    load1 = (tick_n == CNT_W'(STOP1));
                    load2 = (tick_n == CNT_W'(STOP2));
                    if (load2) begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                result_d       = res_w;
                credits_d      = sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
                result_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            credits_q      <= CREDIT_W'(INIT_CREDITS);
            result_q       <= RES_NONE;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            credits_q      <= credits_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.reel0        = sym0;
    assign bus.reel1        = sym1;
    assign bus.reel2        = sym2;
    assign bus.reel_stopped = {stop2, stop1, stop0};
    assign bus.rand_en      = (state_q == SPIN);
    assign bus.busy         = (state_q != IDLE);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.credits      = credits_q;
    assign bus.no_credit    = (credits_q < CREDIT_W'(BET));

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Scoreboard bench: a spin-level reference model predicts each outcome, a monitor
// compares on every result_valid pulse. Two extra instances cover 0 and 250 credits.
module tb_slot_reel_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    slot_reel_ctrl_if #(.CREDIT_W(8)) bus ();
    slot_reel_ctrl_if #(.CREDIT_W(8)) ih ();
    slot_reel_ctrl_if #(.CREDIT_W(8)) iz ();

    assign ih.start     = bus.start;
    assign ih.step_tick = bus.step_tick;
    assign ih.rand_num  = bus.rand_num;
    assign iz.start     = bus.start;
    assign iz.step_tick = bus.step_tick;
    assign iz.rand_num  = bus.rand_num;

    slot_reel_ctrl #(.INIT_CREDITS(10))  dut   (.clk(clk), .rst(rst), .bus(bus));
    slot_reel_ctrl #(.INIT_CREDITS(250)) dut_h (.clk(clk), .rst(rst), .bus(ih));
    slot_reel_ctrl #(.INIT_CREDITS(0))   dut_z (.clk(clk), .rst(rst), .bus(iz));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int res;
        int cred;
        int reels;
    } exp_t;
    exp_t sbq[$];

    // Reference model state
    int m_cred, h_cred;
    int m_reel[3];
    bit m_stop[3];
    int stop_at[3] = '{8, 12, 16};
    int pay_tab[4] = '{0, 2, 10, 50};
    int rv_count = 0;
    bit rv_prev  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int outcome(input int a, input int b, input int c);
        if (a == b && b == c) return (a == 7) ? 3 : 2;
        if (a == b || a == c || b == c) return 1;
        return 0;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int model_reels();
        return m_reel[2] * 256 + m_reel[1] * 16 + m_reel[0];
    endfunction

    function automatic int model_stopped();
        return int'(m_stop[2]) * 4 + int'(m_stop[1]) * 2 + int'(m_stop[0]);
    endfunction

    function automatic int dut_reels();
        return int'({bus.reel2, bus.reel1, bus.reel0});
    endfunction

    // Monitor: one scoreboard entry per result_valid pulse; pulse must be one cycle.
    always @(negedge clk) begin
        if (bus.result_valid) begin
            exp_t e;
            rv_count++;
            check("rv_pulse_width", int'(rv_prev), 0);
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rv_unexpected: got result_valid with empty scoreboard");
            end else begin
                e = sbq.pop_front();
                check("result", int'(bus.result), e.res);
                check("credits_eval", int'(bus.credits), e.cred);
                check("reels_final", dut_reels(), e.reels);
            end
        end
        rv_prev = bus.result_valid;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cred = 10;
        h_cred = 250;
        for (int i = 0; i < 3; i++) begin
            m_reel[i] = 0;
            m_stop[i] = 1'b1;
        end
    endtask

    task automatic check_reset_values();
        check("rst_credits", int'(bus.credits), 10);
        check("rst_reels", dut_reels(), 0);
        check("rst_stopped", int'(bus.reel_stopped), 7);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_rand_en", int'(bus.rand_en), 0);
        check("rst_no_credit", int'(bus.no_credit), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_rv", int'(bus.result_valid), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_tick(input logic [3:0] r);
        @(negedge clk);
        bus.step_tick = 1'b1;
        bus.rand_num  = r;
        @(negedge clk);
        bus.step_tick = 1'b0;
    endtask

    // One spin. extra: second start at tick 3. chain: leave immediately after the
    // last tick so the next start lands in the result_valid cycle. abort_at>0: rst then.
    task automatic spin(input int v0, input int v1, input int v2,
                        input bit extra, input bit chain, input int abort_at);
        bit acc, h_acc;
        int vals[3];
        int rv_before, r, res;
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
        acc   = (m_cred >= 1);
        h_acc = (h_cred >= 1);
        pulse_start();
        if (acc) begin
            m_cred--;
            for (int i = 0; i < 3; i++) m_stop[i] = 1'b0;
        end
        if (h_acc) h_cred--;
        check("busy_after_start", int'(bus.busy), int'(acc));
        check("rand_en_after_start", int'(bus.rand_en), int'(acc));
        check("credits_after_start", int'(bus.credits), m_cred);
        check("stopped_after_start", int'(bus.reel_stopped), model_stopped());
        check("z_busy", int'(iz.busy), 0);
        check("z_no_credit", int'(iz.no_credit), 1);
        check("z_credits", int'(iz.credits), 0);
        for (int n = 1; n <= 16; n++) begin
            if (n == abort_at) begin
                rv_before = rv_count;
                do_reset();
                check_reset_values();
                repeat (4) @(negedge clk);
                check("abort_no_rv", rv_count - rv_before, 0);
                check("abort_busy", int'(bus.busy), 0);
                return;
            end
            r = $urandom_range(0, 15);
            for (int i = 0; i < 3; i++) if (n == stop_at[i]) r = vals[i];
            if (n == 16 && acc) begin
                res = outcome(vals[0], vals[1], vals[2]);
                m_cred = sat(m_cred + pay_tab[res]);
                sbq.push_back('{res, m_cred, vals[2] * 256 + vals[1] * 16 + vals[0]});
                if (h_acc) h_cred = sat(h_cred + pay_tab[res]);
            end
            rv_before = rv_count;
            do_tick(r[3:0]);
            if (acc) begin
                for (int i = 0; i < 3; i++) begin
                    if (!m_stop[i]) begin
                        if (n == stop_at[i]) begin
                            m_reel[i] = r;
                            m_stop[i] = 1'b1;
                        end else begin
                            m_reel[i] = (m_reel[i] + 1) % 16;
                        end
                    end
                end
            end
            check("reels_tick", dut_reels(), model_reels());
            check("stopped_tick", int'(bus.reel_stopped), model_stopped());
            if (n == 16) check("rand_en_after_last", int'(bus.rand_en), 0);
            if (extra && n == 3) begin
                pulse_start();
                check("extra_start_credits", int'(bus.credits), m_cred);
                check("extra_start_busy", int'(bus.busy), int'(acc));
            end
        end
        if (!chain) begin
            repeat (3) @(negedge clk);
            check("rv_count", rv_count - rv_before, int'(acc));
            check("idle_after_spin", int'(bus.busy), 0);
            check("credits_idle", int'(bus.credits), m_cred);
            check("h_credits", int'(ih.credits), h_cred);
        end
    endtask

    initial begin
        int a, b, mode;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.step_tick = 1'b0;
        bus.rand_num  = 4'h0;
        repeat (2) @(negedge clk);
        do_reset();
        check_reset_values();
        check("h_rst_credits", int'(ih.credits), 250);

        spin(5, 5, 5, 1'b0, 1'b0, 0);     // triple: 10 -> 19
        check("res_triple", int'(bus.result), 2);

        do_reset();
        spin(7, 7, 7, 1'b0, 1'b0, 0);     // jackpot: 59; 250-instance saturates
        check("res_jackpot", int'(bus.result), 3);
        check("h_saturated", int'(ih.credits), 255);

        do_reset();
        spin(3, 3, 9, 1'b0, 1'b0, 0);     // pair: 11
        spin(1, 2, 3, 1'b0, 1'b0, 0);     // none: 10
        check("res_none", int'(bus.result), 0);

        spin($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             1'b1, 1'b0, 0);
        spin(4, 4, 4, 1'b0, 1'b1, 0);     // next start lands on result_valid
        spin(9, 9, 2, 1'b0, 1'b0, 0);

        for (int k = 0; k < 10; k++) begin
            mode = $urandom_range(0, 2);
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            case (mode)
                0: spin(a, a, a, 1'b0, 1'b0, 0);
                1: spin(a, b, a, 1'b0, 1'b0, 0);
                default: spin(a, b, $urandom_range(0, 15), 1'b0, 1'b0, 0);
            endcase
        end

        spin(6, 6, 6, 1'b0, 1'b0, 10);    // reset mid-spin

        check("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
